mem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-port instruction/data RAM (9-bit address, 16-bit data, 1-cycle synchronous read) between the CPU (master 0) and a second bus master (master 1, e.g. program loader/DMA).
- Sits between the masters' mem_cmd/mem_addr/write_data buses and the RAM.
- Round-robin with a bounded burst, so a continuously requesting master cannot starve the other.
- Returns read data with a registered valid strobe.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_rr_pick.sv | 39 +++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared command encodings, ownership type and sizing helpers for the
// two-master RAM arbiter.
package mem_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam int AW_DEF = 9;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_t;

  // Width of the burst counter; it only ever has to hold MAX_BURST-1.
  function automatic int burst_w(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

  function automatic logic req_valid(input logic req, input logic [1:0] cmd);
    return req && (cmd != MNONE);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-way winner select: the current owner keeps the RAM for a
// bounded burst, otherwise the master that did not win last time goes next.
module rr_pick
  import mem_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int BCW       = burst_w(MAX_BURST)
) (
  input  logic [1:0]     valid,
  input  owner_t         owner,
  input  logic [BCW-1:0] burst_cnt,
  input  logic           last_winner,
  output logic [1:0]     grant
);

  localparam logic [BCW-1:0] BURST_LIM = BCW'(MAX_BURST - 1);

  // Owner may continue only while its burst has room left.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if ((owner == OWN_M0) && (burst_cnt < BURST_LIM)) begin
          grant = 2'b01;
        end else if ((owner == OWN_M1) && (burst_cnt < BURST_LIM)) begin
          grant = 2'b10;
        end else if (last_winner) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin/bounded-burst arbiter sharing one synchronous single-port RAM
// between two bus masters, with a registered read-valid return path.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [1:0]    m0_cmd,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [1:0]    m1_cmd,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int BCW = burst_w(MAX_BURST);
  localparam logic [BCW-1:0] BURST_LIM = BCW'(MAX_BURST - 1);

  logic [1:0]     valid_s;
  logic [1:0]     pick_s;
  logic [1:0]     grant_s;
  logic [1:0]     rvalid_r;
  owner_t         owner_r;
  owner_t         win_owner_s;
  logic           last_winner_r;
  logic [BCW-1:0] burst_cnt_r;
  logic [BCW-1:0] burst_nxt_s;
  logic [1:0]     cmd_s;
  logic [AW-1:0]  addr_s;
  logic [DW-1:0]  wdata_s;

  assign valid_s = {req_valid(m1_req, m1_cmd), req_valid(m0_req, m0_cmd)};

  rr_pick #(
    .MAX_BURST (MAX_BURST),
    .BCW       (BCW)
  ) u_pick (
    .valid       (valid_s),
    .owner       (owner_r),
    .burst_cnt   (burst_cnt_r),
    .last_winner (last_winner_r),
    .grant       (pick_s)
  );

  // Grants are suppressed while reset is held so the RAM sees MNONE at once.
  assign grant_s = reset ? pick_s : 2'b00;

  // Route the winning master onto the RAM bus with no added latency.
  always_comb begin
    cmd_s       = MNONE;
    addr_s      = {AW{1'b0}};
    wdata_s     = {DW{1'b0}};
    win_owner_s = OWN_NONE;
    case (grant_s)
      2'b01: begin
        cmd_s       = m0_cmd;
        addr_s      = m0_addr;
        wdata_s     = m0_wdata;
        win_owner_s = OWN_M0;
      end
      2'b10: begin
        cmd_s       = m1_cmd;
        addr_s      = m1_addr;
        wdata_s     = m1_wdata;
        win_owner_s = OWN_M1;
      end
      default: begin
        cmd_s       = MNONE;
        addr_s      = {AW{1'b0}};
        wdata_s     = {DW{1'b0}};
        win_owner_s = OWN_NONE;
      end
    endcase
  end

  // Saturating burst count for a repeat winner, restart on a change of owner.
  always_comb begin
    burst_nxt_s = {BCW{1'b0}};
    if (win_owner_s == owner_r) begin
      if (burst_cnt_r < BURST_LIM) begin
        burst_nxt_s = burst_cnt_r + BCW'(1);
      end else begin
        burst_nxt_s = BURST_LIM;
      end
    end else begin
      burst_nxt_s = {BCW{1'b0}};
    end
  end

  // Arbitration history and the one-cycle read-valid pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r       <= OWN_NONE;
      last_winner_r <= 1'b1;
      burst_cnt_r   <= {BCW{1'b0}};
      rvalid_r      <= 2'b00;
    end else begin
      if (grant_s != 2'b00) begin
        owner_r       <= win_owner_s;
        last_winner_r <= grant_s[1];
        burst_cnt_r   <= burst_nxt_s;
      end else begin
        owner_r     <= OWN_NONE;
        burst_cnt_r <= {BCW{1'b0}};
      end
      rvalid_r <= (cmd_s == MREAD) ? grant_s : 2'b00;
    end
  end

  assign mem_cmd   = cmd_s;
  assign mem_addr  = addr_s;
  assign mem_wdata = wdata_s;

  assign m0_gnt    = grant_s[0];
  assign m1_gnt    = grant_s[1];
  assign m0_rvalid = rvalid_r[0];
  assign m1_rvalid = rvalid_r[1];
  assign m0_rdata  = rvalid_r[0] ? mem_rdata : {DW{1'b0}};
  assign m1_rdata  = rvalid_r[1] ? mem_rdata : {DW{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 uses MAX_BURST=4, instance 1
// uses MAX_BURST=1, each with its own RAM and reference model.
module tb_mem_arbiter;
  import mem_pkg::*;

  typedef struct {
    logic [1:0]  gnt;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wd;
  } exp_t;

  typedef struct {
    int          m;
    logic [15:0] d;
    int          cyc;
  } rd_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  logic        req   [2][2];
  logic [1:0]  cmd   [2][2];
  logic [8:0]  addr  [2][2];
  logic [15:0] wdata [2][2];
  logic        gnt   [2][2];
  logic        rvalid[2][2];
  logic [15:0] rdata [2][2];
  logic [1:0]  mcmd  [2];
  logic [8:0]  maddr [2];
  logic [15:0] mwd   [2];
  logic [15:0] mrd   [2];

  exp_t exp_q[2][$];
  rd_t  rd_q[2][$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: run length of the current owner and the last winner.
  int          mb[2] = '{4, 1};
  int          cur[2];
  int          streak[2];
  int          last[2];
  logic        granted[2][2];
  logic [15:0] ref_mem[2][512];
  logic [8:0]  last_wa[2][2];

  function automatic logic [15:0] init_val(input int i);
    if (i == 5) return 16'hBEEF;
    return 16'(i * 40503 + 4660);
  endfunction

  always #5 clk = ~clk;

  // Cycle counter shared by stimulus and monitor.
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [15:0]  ram [512];
    logic [511:0] written = 512'd0;
    logic [15:0]  rq = 16'h0000;

    // Behavioural single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
      if (mcmd[k] == MWRITE) begin
        ram[maddr[k]]     <= mwd[k];
        written[maddr[k]] <= 1'b1;
      end
      if (mcmd[k] == MREAD) rq <= written[maddr[k]] ? ram[maddr[k]] : init_val(int'(maddr[k]));
    end
    assign mrd[k] = rq;

    mem_arbiter #(.AW(9), .DW(16), .MAX_BURST((k == 0) ? 4 : 1)) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(req[k][0]), .m0_cmd(cmd[k][0]), .m0_addr(addr[k][0]), .m0_wdata(wdata[k][0]),
      .m0_gnt(gnt[k][0]), .m0_rvalid(rvalid[k][0]), .m0_rdata(rdata[k][0]),
      .m1_req(req[k][1]), .m1_cmd(cmd[k][1]), .m1_addr(addr[k][1]), .m1_wdata(wdata[k][1]),
      .m1_gnt(gnt[k][1]), .m1_rvalid(rvalid[k][1]), .m1_rdata(rdata[k][1]),
      .mem_cmd(mcmd[k]), .mem_addr(maddr[k]), .mem_wdata(mwd[k]), .mem_rdata(mrd[k])
    );
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d actual=%0h required=%0h", name, k, cyc, act, req_v);
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectations.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (exp_q[k].size() > 0) begin
        exp_t        e;
        rd_t         r;
        logic [1:0]  rv;
        logic [15:0] d0;
        logic [15:0] d1;
        e  = exp_q[k].pop_front();
        rv = 2'b00;
        d0 = 16'h0000;
        d1 = 16'h0000;
        if (rd_q[k].size() > 0 && rd_q[k][0].cyc == cyc) begin
          r = rd_q[k].pop_front();
          rv[r.m] = 1'b1;
          if (r.m == 0) d0 = r.d;
          else d1 = r.d;
        end
        chk("gnt", k, 32'({gnt[k][1], gnt[k][0]}), 32'(e.gnt));
        chk("mem_cmd_addr", k, 32'({mcmd[k], maddr[k]}), 32'({e.cmd, e.addr}));
        chk("mem_wdata", k, 32'(mwd[k]), 32'(e.wd));
        chk("rvalid", k, 32'({rvalid[k][1], rvalid[k][0]}), 32'(rv));
        chk("m0_rdata", k, 32'(rdata[k][0]), 32'(d0));
        chk("m1_rdata", k, 32'(rdata[k][1]), 32'(d1));
      end
    end
  end

  // Decide this cycle's winner from the arbitration rules and queue the result.
  task automatic eval();
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      bit   v0;
      bit   v1;
      int   w;
      e = '{2'b00, MNONE, 9'd0, 16'h0000};
      if (!reset) begin
        cur[k] = -1;
        streak[k] = 0;
        last[k] = 1;
        rd_q[k].delete();
        granted[k][0] = 1'b0;
        granted[k][1] = 1'b0;
      end else begin
        v0 = req[k][0] && (cmd[k][0] != MNONE);
        v1 = req[k][1] && (cmd[k][1] != MNONE);
        w = -1;
        if (v0 && v1) w = (streak[k] > 0 && streak[k] < mb[k]) ? cur[k] : 1 - last[k];
        else if (v0) w = 0;
        else if (v1) w = 1;
        granted[k][0] = (w == 0);
        granted[k][1] = (w == 1);
        if (w >= 0) begin
          e.gnt[w] = 1'b1;
          e.cmd    = cmd[k][w];
          e.addr   = addr[k][w];
          e.wd     = wdata[k][w];
          streak[k] = (w == cur[k]) ? streak[k] + 1 : 1;
          cur[k] = w;
          last[k] = w;
          if (e.cmd == MWRITE) ref_mem[k][e.addr] = e.wd;
          else if (e.cmd == MREAD) rd_q[k].push_back('{w, ref_mem[k][e.addr], cyc + 1});
        end else begin
          cur[k] = -1;
          streak[k] = 0;
        end
      end
      exp_q[k].push_back(e);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int k, input int m, input logic r, input logic [1:0] c,
                       input logic [8:0] a, input logic [15:0] w);
    req[k][m] = r;
    cmd[k][m] = c;
    addr[k][m] = a;
    wdata[k][m] = w;
  endtask

  task automatic clear_all();
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < 2; m++) set_m(k, m, 1'b0, MNONE, 9'd0, 16'h0000);
  endtask

  task automatic drop_granted();
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < 2; m++)
        if (granted[k][m]) set_m(k, m, 1'b0, MNONE, 9'd0, 16'h0000);
  endtask

  // Two cycles in reset, then released; caller drives the first live cycle.
  task automatic do_reset();
    next_cycle(); reset = 1'b0; clear_all(); eval();
    next_cycle(); eval();
    next_cycle(); reset = 1'b1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic write_req(input int k, input int m);
    logic [8:0] a;
    a = (m == 0) ? 9'(9'h100 + $urandom_range(0, 15)) : 9'(9'h120 + $urandom_range(0, 15));
    last_wa[k][m] = a;
    set_m(k, m, 1'b1, MWRITE, a, 16'($urandom));
  endtask

  initial begin
    clear_all();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 512; i++) ref_mem[k][i] = init_val(i);
      granted[k][0] = 1'b0;
      granted[k][1] = 1'b0;
    end

    // Reset, then a lone master 0 read of address 5.
    do_reset();
    for (int k = 0; k < 2; k++) set_m(k, 0, 1'b1, MREAD, 9'h005, 16'h0000);
    eval(); sample();
    for (int k = 0; k < 2; k++) begin
      chk("t1_gnt", k, 32'({gnt[k][1], gnt[k][0]}), 32'h1);
      chk("t1_addr", k, 32'({mcmd[k], maddr[k]}), 32'({MREAD, 9'h005}));
    end
    next_cycle(); clear_all(); eval(); sample();
    for (int k = 0; k < 2; k++) begin
      chk("t1_rvalid", k, 32'({rvalid[k][1], rvalid[k][0]}), 32'h1);
      chk("t1_rdata", k, 32'(rdata[k][0]), 32'hBEEF);
    end

    // Simultaneous first request: master 0 wins the first tie.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_m(k, 0, 1'b1, MREAD, 9'h001, 16'h0000);
      set_m(k, 1, 1'b1, MREAD, 9'h002, 16'h0000);
    end
    eval(); sample();
    for (int k = 0; k < 2; k++) chk("t2_first", k, 32'({gnt[k][1], gnt[k][0]}), 32'h1);
    next_cycle(); drop_granted(); eval(); sample();
    for (int k = 0; k < 2; k++) chk("t2_second", k, 32'({gnt[k][1], gnt[k][0]}), 32'h2);
    next_cycle(); clear_all(); eval();

    // Continuous writes from both masters: burst of 4 vs pure alternation.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      write_req(k, 0);
      write_req(k, 1);
    end
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        next_cycle();
        for (int k = 0; k < 2; k++)
          for (int m = 0; m < 2; m++)
            if (granted[k][m]) write_req(k, m);
      end
      eval(); sample();
      chk("t3_burst", 0, 32'({gnt[0][1], gnt[0][0]}), ((i / 4) % 2 == 0) ? 32'h1 : 32'h2);
      chk("t3_alt", 1, 32'({gnt[1][1], gnt[1][0]}), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    next_cycle(); clear_all(); eval();
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      set_m(k, 0, 1'b1, MREAD, last_wa[k][0], 16'h0000);
      set_m(k, 1, 1'b1, MREAD, last_wa[k][1], 16'h0000);
    end
    eval();
    for (int i = 0; i < 3; i++) begin
      next_cycle(); drop_granted(); eval();
    end

    // Master 1 requesting with MNONE is ignored; master 0 is never throttled.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_m(k, 1, 1'b1, MNONE, 9'h1FF, 16'hFFFF);
      set_m(k, 0, 1'b1, MREAD, 9'($urandom_range(0, 511)), 16'h0000);
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        next_cycle();
        for (int k = 0; k < 2; k++) set_m(k, 0, 1'b1, MREAD, 9'($urandom_range(0, 511)), 16'h0000);
      end
      eval(); sample();
      for (int k = 0; k < 2; k++) chk("t4_gnt", k, 32'({gnt[k][1], gnt[k][0]}), 32'h1);
    end
    next_cycle(); clear_all(); eval();

    // Reset lands between a granted read and its return edge.
    do_reset();
    for (int k = 0; k < 2; k++) set_m(k, 1, 1'b1, MREAD, 9'h007, 16'h0000);
    eval(); sample();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) rd_q[k].delete();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t5_gnt_rvalid", k, 32'({gnt[k][1], gnt[k][0], rvalid[k][1], rvalid[k][0]}), 32'h0);
      chk("t5_rdata", k, 32'({rdata[k][1], rdata[k][0]}), 32'h0);
      chk("t5_mem_bus", k, 32'({mcmd[k], maddr[k]}), 32'h0);
      chk("t5_mem_wdata", k, 32'(mwd[k]), 32'h0);
    end
    next_cycle(); clear_all(); eval();
    next_cycle(); eval();
    next_cycle(); reset = 1'b1; eval(); sample();
    for (int k = 0; k < 2; k++) chk("t5_no_rvalid", k, 32'({rvalid[k][1], rvalid[k][0]}), 32'h0);

    // Back-to-back reads of addresses 1 and 2 from both masters.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_m(k, 0, 1'b1, MREAD, 9'h001, 16'h0000);
      set_m(k, 1, 1'b1, MREAD, 9'h002, 16'h0000);
    end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) next_cycle();
      eval(); sample();
      if (i > 0) begin
        chk("t6_rv_alt", 1, 32'({rvalid[1][1], rvalid[1][0]}), (i % 2 == 1) ? 32'h1 : 32'h2);
        chk("t6_rdata", 1, (i % 2 == 1) ? 32'(rdata[1][0]) : 32'(rdata[1][1]),
            (i % 2 == 1) ? 32'(init_val(1)) : 32'(init_val(2)));
      end
    end
    next_cycle(); clear_all(); eval();

    // Randomized traffic honouring the hold-until-grant protocol.
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      for (int k = 0; k < 2; k++) begin
        for (int m = 0; m < 2; m++) begin
          int r;
          if (!(req[k][m] && cmd[k][m] != MNONE && !granted[k][m])) begin
            r = int'($urandom_range(0, 9));
            if (r < 3) set_m(k, m, 1'b0, MNONE, 9'd0, 16'h0000);
            else if (r == 3) set_m(k, m, 1'b1, MNONE, 9'($urandom_range(0, 511)), 16'($urandom));
            else if (r < 7) set_m(k, m, 1'b1, MREAD, 9'($urandom_range(0, 63)), 16'h0000);
            else set_m(k, m, 1'b1, MWRITE, 9'($urandom_range(0, 63)), 16'($urandom));
          end
        end
      end
      eval();
    end
    next_cycle(); clear_all(); eval();
    next_cycle(); eval(); sample();
    for (int k = 0; k < 2; k++) chk("rd_drain", k, 32'(rd_q[k].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
